decision_tree_classifier: RTL and testbench

- Hardware inference engine for a CAN-bus intrusion detector.
- Takes one pre-extracted feature vector per CAN frame and walks a fixed binary decision tree, one node per clock.
- Reports the leaf reached, the attack/normal class, the traversal depth, and an error flag for malformed trees or depth overrun.
- Sits between the CAN feature extractor and the alert/logging logic.

---
 rtl/dt_pkg.sv | 71 +++++++
 rtl/dt_node_rom.sv | 19 +
 rtl/decision_tree_classifier.sv | 135 +++++++++++++
 tb/tb_decision_tree_classifier.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared types and the fixed default tree for the CAN-bus decision-tree classifier.
// Node records are packed so the ROM can hand a whole record to the walker in one word.
package dt_pkg;

  localparam int NODE_IDX_W = 8;
  localparam int DEPTH_W    = 8;
  localparam int THRESH_W   = 32;

  // Feature selectors; encodings 6 and 7 are reserved and mark a malformed node.
  localparam logic [2:0] FEAT_ARB_ID     = 3'd0;
  localparam logic [2:0] FEAT_DLC        = 3'd1;
  localparam logic [2:0] FEAT_FIRST_BYTE = 3'd2;
  localparam logic [2:0] FEAT_LAST_BYTE  = 3'd3;
  localparam logic [2:0] FEAT_BYTE_SUM   = 3'd4;
  localparam logic [2:0] FEAT_TIME_DELTA = 3'd5;

  typedef struct packed {
    logic                  is_leaf;
    logic                  leaf_class;
    logic [2:0]            feature_sel;
    logic [THRESH_W-1:0]   threshold;
    logic [NODE_IDX_W-1:0] left;
    logic [NODE_IDX_W-1:0] right;
  } node_t;

  typedef struct packed {
    logic [10:0] arb_id_dec;
    logic [3:0]  data_length;
    logic [7:0]  first_byte;
    logic [7:0]  last_byte;
    logic [10:0] byte_sum;
    logic [31:0] time_delta;
  } features_t;

  typedef enum logic {
    ST_IDLE,
    ST_EVAL
  } state_e;

  function automatic node_t make_split(input logic [2:0]            sel,
                                       input logic [THRESH_W-1:0]   thr,
                                       input logic [NODE_IDX_W-1:0] l,
                                       input logic [NODE_IDX_W-1:0] r);
    return '{is_leaf: 1'b0, leaf_class: 1'b0, feature_sel: sel,
             threshold: thr, left: l, right: r};
  endfunction

  function automatic node_t make_leaf(input logic cls);
    return '{is_leaf: 1'b1, leaf_class: cls, feature_sel: FEAT_ARB_ID,
             threshold: '0, left: '0, right: '0};
  endfunction

  // Anything outside the table reads as a split on a reserved feature, so a stray
  // address always ends the walk with an error instead of a bogus classification.
  localparam node_t INVALID_NODE = '{is_leaf: 1'b0, leaf_class: 1'b0,
                                     feature_sel: 3'd7, threshold: '0,
                                     left: '0, right: '0};

  localparam int DEFAULT_NUM_NODES = 7;

  localparam node_t DEFAULT_TREE [DEFAULT_NUM_NODES] = '{
    make_split(FEAT_TIME_DELTA, 32'd50,  8'd1, 8'd2),
    make_split(FEAT_ARB_ID,     32'd255, 8'd3, 8'd4),
    make_leaf(1'b0),
    make_leaf(1'b1),
    make_split(FEAT_BYTE_SUM,   32'd600, 8'd5, 8'd6),
    make_leaf(1'b0),
    make_leaf(1'b1)
  };

endpackage

// File: rtl/dt_node_rom.sv
// Combinational node table: maps a node index onto its record in the default tree.
module dt_node_rom
  import dt_pkg::*;
(
  input  logic [NODE_IDX_W-1:0] addr_i,
  output node_t                 node_o
);

  always_comb begin
    // NOTE: node_o gets a value before any conditional path so no latch is inferred.
    node_o = INVALID_NODE;
    for (int i = 0; i < DEFAULT_NUM_NODES; i++) begin
      if (addr_i == NODE_IDX_W'(i)) begin
        node_o = DEFAULT_TREE[i];
      end
    end
  end

endmodule

// File: rtl/decision_tree_classifier.sv
// Walks the decision tree one node per clock for a latched CAN feature vector and
// reports leaf, class, depth and an error flag for malformed trees or depth overrun.
module decision_tree_classifier
  import dt_pkg::*;
#(
  parameter int NUM_NODES = 7,
  parameter int MAX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] arb_id_dec,
  input  logic [3:0]  data_length,
  input  logic [7:0]  first_byte,
  input  logic [7:0]  last_byte,
  input  logic [10:0] byte_sum,
  input  logic [31:0] time_delta,
  output logic        done,
  output logic        is_attack,
  output logic [7:0]  final_node,
  output logic        error,
  output logic [7:0]  tree_depth
);

  localparam logic [NODE_IDX_W-1:0] NODE_LIMIT  = NODE_IDX_W'(NUM_NODES);
  localparam logic [DEPTH_W-1:0]    DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);

  state_e                  state_q;
  features_t               feat_q;
  features_t               feat_d;
  logic [NODE_IDX_W-1:0]   node_idx_q;
  logic [DEPTH_W-1:0]      depth_cnt_q;
  logic                    done_q;
  logic                    is_attack_q;
  logic [NODE_IDX_W-1:0]   final_node_q;
  logic                    error_q;
  logic [DEPTH_W-1:0]      tree_depth_q;

  node_t                   node;
  logic [THRESH_W-1:0]     feat_val;
  logic                    feat_valid;
  logic [NODE_IDX_W-1:0]   child_idx;
  logic                    child_bad;
  logic                    depth_hit;

  assign feat_d = '{arb_id_dec:  arb_id_dec,
                    data_length: data_length,
                    first_byte:  first_byte,
                    last_byte:   last_byte,
                    byte_sum:    byte_sum,
                    time_delta:  time_delta};

  dt_node_rom u_rom (
    .addr_i (node_idx_q),
    .node_o (node)
  );

  // Feature mux and unsigned compare against the current node's threshold.
  always_comb begin
    feat_val   = '0;
    feat_valid = 1'b1;
    case (node.feature_sel)
      FEAT_ARB_ID:     feat_val = THRESH_W'(feat_q.arb_id_dec);
      FEAT_DLC:        feat_val = THRESH_W'(feat_q.data_length);
      FEAT_FIRST_BYTE: feat_val = THRESH_W'(feat_q.first_byte);
      FEAT_LAST_BYTE:  feat_val = THRESH_W'(feat_q.last_byte);
      FEAT_BYTE_SUM:   feat_val = THRESH_W'(feat_q.byte_sum);
      FEAT_TIME_DELTA: feat_val = feat_q.time_delta;
      default:         feat_valid = 1'b0;
    endcase
  end

  assign child_idx = (feat_val <= node.threshold) ? node.left : node.right;
  assign child_bad = (child_idx >= NODE_LIMIT);
  assign depth_hit = (depth_cnt_q == DEPTH_LIMIT);

  // NOTE: state and outputs update with non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      feat_q       <= '0;
      node_idx_q   <= '0;
      depth_cnt_q  <= '0;
      done_q       <= 1'b0;
      is_attack_q  <= 1'b0;
      final_node_q <= '0;
      error_q      <= 1'b0;
      tree_depth_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            feat_q      <= feat_d;
            node_idx_q  <= '0;
            depth_cnt_q <= '0;
            error_q     <= 1'b0;
            is_attack_q <= 1'b0;
            state_q     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // A leaf wins even when the depth budget is exhausted at the same node.
          if (node.is_leaf) begin
            final_node_q <= node_idx_q;
            is_attack_q  <= node.leaf_class;
            tree_depth_q <= depth_cnt_q;
            error_q      <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= ST_IDLE;
          end else if (!feat_valid || child_bad || depth_hit) begin
            final_node_q <= node_idx_q;
            is_attack_q  <= 1'b0;
            tree_depth_q <= depth_cnt_q;
            error_q      <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            node_idx_q  <= child_idx;
            depth_cnt_q <= depth_cnt_q + DEPTH_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign is_attack  = is_attack_q;
  assign final_node = final_node_q;
  assign error      = error_q;
  assign tree_depth = tree_depth_q;

endmodule

// File: tb/tb_decision_tree_classifier.sv
// Bench for decision_tree_classifier: a default instance and a MAX_DEPTH=1 instance,
// directed and randomized frames checked against a tree-walking reference model.
module tb_decision_tree_classifier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [10:0] arb_id_dec = '0;
  logic [3:0]  data_length = '0;
  logic [7:0]  first_byte = '0;
  logic [7:0]  last_byte = '0;
  logic [10:0] byte_sum = '0;
  logic [31:0] time_delta = '0;

  logic       done_a, is_attack_a, error_a;
  logic [7:0] final_node_a, tree_depth_a;
  logic       done_b, is_attack_b, error_b;
  logic [7:0] final_node_b, tree_depth_b;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  always #5 clk = ~clk;

  decision_tree_classifier #(.NUM_NODES(7), .MAX_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .arb_id_dec(arb_id_dec), .data_length(data_length), .first_byte(first_byte),
    .last_byte(last_byte), .byte_sum(byte_sum), .time_delta(time_delta),
    .done(done_a), .is_attack(is_attack_a), .final_node(final_node_a),
    .error(error_a), .tree_depth(tree_depth_a)
  );

  decision_tree_classifier #(.NUM_NODES(7), .MAX_DEPTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .arb_id_dec(arb_id_dec), .data_length(data_length), .first_byte(first_byte),
    .last_byte(last_byte), .byte_sum(byte_sum), .time_delta(time_delta),
    .done(done_b), .is_attack(is_attack_b), .final_node(final_node_b),
    .error(error_b), .tree_depth(tree_depth_b)
  );

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference tree as written in the node table: feature index, threshold, children.
  int          m_leaf [7] = '{0, 0, 1, 1, 0, 1, 1};
  int          m_cls  [7] = '{0, 0, 0, 1, 0, 0, 1};
  int          m_feat [7] = '{5, 0, 0, 0, 4, 0, 0};
  longint      m_thr  [7] = '{50, 255, 0, 0, 600, 0, 0};
  int          m_left [7] = '{1, 3, 0, 0, 5, 0, 0};
  int          m_right[7] = '{2, 4, 0, 0, 6, 0, 0};

  task automatic model(input logic [10:0] arb, input logic [3:0] dlc,
                       input logic [7:0] fb, input logic [7:0] lb,
                       input logic [10:0] sum, input logic [31:0] td,
                       input int max_depth,
                       output int leaf, output int cls, output int depth, output int err);
    longint f [6];
    int node;
    f[0] = longint'(arb); f[1] = longint'(dlc); f[2] = longint'(fb);
    f[3] = longint'(lb);  f[4] = longint'(sum); f[5] = longint'(td);
    node = 0; depth = 0; err = 0; cls = 0; leaf = 0;
    for (int step = 0; step < 64; step++) begin
      if (m_leaf[node] == 1) begin
        leaf = node; cls = m_cls[node];
        return;
      end
      if (depth == max_depth) begin
        leaf = node; err = 1;
        return;
      end
      node = (f[m_feat[node]] <= m_thr[node]) ? m_left[node] : m_right[node];
      depth++;
    end
  endtask

  task automatic drive(input logic [10:0] arb, input logic [3:0] dlc,
                       input logic [7:0] fb, input logic [7:0] lb,
                       input logic [10:0] sum, input logic [31:0] td);
    arb_id_dec = arb; data_length = dlc; first_byte = fb;
    last_byte = lb; byte_sum = sum; time_delta = td;
  endtask

  task automatic scramble();
    drive(11'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
          11'($urandom), $urandom);
  endtask

  // One frame on instance a (sel=0) or b (sel=1); checks latency, outputs, pulse width.
  task automatic run_frame(input string tag, input bit sel,
                           input logic [10:0] arb, input logic [3:0] dlc,
                           input logic [7:0] fb, input logic [7:0] lb,
                           input logic [10:0] sum, input logic [31:0] td);
    int e_leaf, e_cls, e_depth, e_err, lat;
    model(arb, dlc, fb, lb, sum, td, sel ? 1 : 16, e_leaf, e_cls, e_depth, e_err);
    @(negedge clk);
    drive(arb, dlc, fb, lb, sum, td);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    scramble();
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ((sel ? done_b : done_a) === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(e_depth + 1));
    check({tag, "_node"},   64'(sel ? final_node_b : final_node_a), 64'(e_leaf));
    check({tag, "_class"},  64'(sel ? is_attack_b  : is_attack_a),  64'(e_cls));
    check({tag, "_depth"},  64'(sel ? tree_depth_b : tree_depth_a), 64'(e_depth));
    check({tag, "_error"},  64'(sel ? error_b      : error_a),      64'(e_err));
    @(negedge clk);
    check({tag, "_pulse"},  64'(sel ? done_b : done_a), 64'd0);
    check({tag, "_hold"},   64'(sel ? final_node_b : final_node_a), 64'(e_leaf));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_done_a"},  64'(done_a), 64'd0);
    check({tag, "_attack_a"}, 64'(is_attack_a), 64'd0);
    check({tag, "_node_a"},  64'(final_node_a), 64'd0);
    check({tag, "_error_a"}, 64'(error_a), 64'd0);
    check({tag, "_depth_a"}, 64'(tree_depth_a), 64'd0);
    check({tag, "_node_b"},  64'(final_node_b), 64'd0);
    check({tag, "_error_b"}, 64'(error_b), 64'd0);
  endtask

  initial begin
    logic [10:0] r_arb, r_sum;
    logic [31:0] r_td;
    int cnt_before;

    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // Directed frames from the test plan on the default instance.
    run_frame("normal",  1'b0, 11'd510, 4'd0, 8'd6,   8'd84, 11'd474, 32'd0);
    run_frame("low_id",  1'b0, 11'd250, 4'd8, 8'd200, 8'd50, 11'd800, 32'd10);
    run_frame("zeros",   1'b0, 11'd0,   4'd0, 8'd0,   8'd0,  11'd0,   32'd0);
    run_frame("td51",    1'b0, 11'd0,   4'd0, 8'd0,   8'd0,  11'd0,   32'd51);
    run_frame("td50",    1'b0, 11'd0,   4'd0, 8'd0,   8'd0,  11'd0,   32'd50);
    run_frame("arb255",  1'b0, 11'd255, 4'd0, 8'd0,   8'd0,  11'd601, 32'd3);
    run_frame("sum601",  1'b0, 11'd256, 4'd0, 8'd0,   8'd0,  11'd601, 32'd3);

    // Depth-limited instance: overrun, then a shallow frame that recovers.
    run_frame("depth_err", 1'b1, 11'd510, 4'd0, 8'd6, 8'd84, 11'd474, 32'd0);
    run_frame("depth_ok",  1'b1, 11'd0,   4'd0, 8'd0, 8'd0,  11'd0,   32'd100);

    // Randomized frames biased toward the three thresholds.
    for (int i = 0; i < 40; i++) begin
      r_arb = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(250, 260)) : 11'($urandom);
      r_sum = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(595, 605)) : 11'($urandom);
      r_td  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(45, 55));
      run_frame("rand_a", 1'b0, r_arb, 4'($urandom), 8'($urandom), 8'($urandom), r_sum, r_td);
    end
    for (int i = 0; i < 10; i++) begin
      r_arb = 11'($urandom);
      r_td  = 32'($urandom_range(0, 100));
      run_frame("rand_b", 1'b1, r_arb, 4'($urandom), 8'($urandom), 8'($urandom),
                11'($urandom), r_td);
    end

    // A second start during the walk must be ignored.
    cnt_before = done_cnt_a;
    @(negedge clk);
    drive(11'd510, 4'd0, 8'd6, 8'd84, 11'd474, 32'd0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    drive(11'd0, 4'd0, 8'd0, 8'd0, 11'd0, 32'd1000);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    check("restart_done_count", 64'(done_cnt_a - cnt_before), 64'd1);
    check("restart_node", 64'(final_node_a), 64'd5);
    check("restart_depth", 64'(tree_depth_a), 64'd3);

    // Reset mid-walk clears outputs and produces no done pulse.
    cnt_before = done_cnt_a;
    @(negedge clk);
    drive(11'd510, 4'd0, 8'd6, 8'd84, 11'd474, 32'd0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_no_done", 64'(done_cnt_a - cnt_before), 64'd0);
    check("midreset_node_after", 64'(final_node_a), 64'd0);

    run_frame("post_reset", 1'b0, 11'd510, 4'd0, 8'd6, 8'd84, 11'd474, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
